// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store initiator for word-only DataMemory
module load_store_unit #(
  parameter int MEM_WORDS = 256,
  parameter int ADDR_W    = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              MR,
  output logic              MW,
  output logic [ADDR_W-1:0] Addr,
  output logic [31:0]       WD,
  input  logic [31:0]       RD
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  // First byte address past the end of DataMemory.
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(MEM_WORDS) << 2;

  state_t      state;
  logic [1:0]  lat_lane;
  logic [1:0]  lat_size;
  logic        lat_we;
  logic        lat_uns;
  logic [15:0] lat_wdata;
  logic        acc_err;

  // Move the addressed lane(s) down to bit 0 and extend to a full word.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      2'b00:   return uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return word;
    endcase
  endfunction

  // Replace only the addressed lane(s) of the word read back from memory.
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic [15:0] wd);
    logic [31:0] m;
    m = word;
    if (size == 2'b00) m[{lane, 3'b000} +: 8] = wd[7:0];
    else               m[{lane[1], 4'b0000} +: 16] = wd;
    return m;
  endfunction

  // Classify the incoming request: illegal size, misalignment or out of range.
  always_comb begin
    acc_err = 1'b0;
    case (req_size)
      2'b01:   acc_err = req_addr[0];
      2'b10:   acc_err = |req_addr[1:0];
      2'b11:   acc_err = 1'b1;
      default: acc_err = 1'b0;
    endcase
    if ({1'b0, req_addr} >= ADDR_LIMIT) acc_err = 1'b1;
  end

  // Request/response sequencer; every output is a register so MR/MW are glitch-free.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      MR         <= 1'b0;
      MW         <= 1'b0;
      Addr       <= '0;
      WD         <= 32'h0;
      lat_lane   <= 2'b00;
      lat_size   <= 2'b00;
      lat_we     <= 1'b0;
      lat_uns    <= 1'b0;
      lat_wdata  <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            lat_lane  <= req_addr[1:0];
            lat_size  <= req_size;
            lat_we    <= req_we;
            lat_uns   <= req_unsigned;
            lat_wdata <= req_wdata[15:0];
            req_ready <= 1'b0;
            if (acc_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else begin
              Addr <= {req_addr[ADDR_W-1:2], 2'b00};
              if (req_we && req_size == 2'b10) begin
                // Full-word stores need no read-back.
                state <= WRITE;
                MW    <= 1'b1;
                WD    <= req_wdata;
              end else begin
                state <= READ;
                MR    <= 1'b1;
              end
            end
          end
        end
        READ: begin
          MR <= 1'b0;
          if (lat_we) begin
            state <= WRITE;
            MW    <= 1'b1;
            WD    <= store_merge(RD, lat_lane, lat_size, lat_wdata);
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_extract(RD, lat_lane, lat_size, lat_uns);
          end
        end
        WRITE: begin
          MW         <= 1'b0;
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
        end
        RESP: begin
          if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the DataMemory interface. The MEM stage hands it byte-addressed load/store requests; it drives MR, MW, Addr and WD into the word-only DataMemory.
- Adds byte and halfword access: sub-word stores are done by read-modify-write, and sub-word loads are sign- or zero-extended.
- Checks alignment and address range, and reports a response to the pipeline over a valid/ready handshake.

Parameters:
- MEM_WORDS, 256, number of 32-bit words in DataMemory; byte addresses >= MEM_WORDS*4 are out of range.
- ADDR_W, 32, width of the request and memory address.

Ports:
- Clk  in  1  rising-edge clock, shared with DataMemory.
- Rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  load result after extension; 0 for stores.
- resp_err  out  1  misaligned, illegal size, or out-of-range access.
- MR  out  1  DataMemory read enable.
- MW  out  1  DataMemory write enable.
- Addr  out  ADDR_W  word-aligned byte address to DataMemory (bits [1:0] = 0).
- WD  out  32  DataMemory write data.
- RD  in  32  DataMemory read data.

Behaviour:
- DataMemory contract: RD is combinational from Addr while MR=1. A write occurs at posedge Clk when MW=1.
- All outputs are registered.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, MR=0, MW=0, Addr=0, WD=0, state=IDLE.
- State machine: IDLE, READ, WRITE, RESP.
- Only IDLE has req_ready=1. A request is accepted when req_valid && req_ready at a posedge. On acceptance, addr, size, we, unsigned and wdata are latched.
- Error check at acceptance; on error go directly to RESP with resp_err=1, resp_rdata=0, and no MR/MW issued. An access is in error if any of these hold:
  - size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr >= MEM_WORDS*4.
- Load, or sub-word store → READ. READ drives MR=1 and Addr={addr[31:2],2'b00} for exactly one cycle, and RD is captured at the end of that cycle.
- Word store → WRITE directly.
- READ → RESP for a load, or → WRITE for a sub-word store.
- WRITE drives MW=1 for exactly one cycle, then goes to RESP.
- Byte lanes are little-endian: lane = addr[1:0]; a halfword uses lanes addr[1]*2 and addr[1]*2+1.
- Store merge: the word written is the captured RD with only the addressed lane(s) replaced by wdata[7:0] or wdata[15:0]. A word store writes wdata unmodified.
- Load extract: shift the selected lane(s) down to bit 0, then sign- or zero-extend to 32 bits.
- RESP: resp_valid=1. resp_rdata and resp_err are held stable until resp_valid && resp_ready at a posedge; then return to IDLE with req_ready=1 on the next cycle.
- MR and MW are never both 1. Outside READ/WRITE both are 0.
- Latency from the accepting edge to resp_valid rising:
  - load: 2 edges;
  - word store: 2 edges;
  - sub-word store: 3 edges;
  - error: 1 edge.
- Throughput: at most one request in flight; no pipelining.
- A back-pressured response (resp_ready=0) stalls in RESP indefinitely and accepts no new request.
- Reset mid-operation: all state and outputs return to reset values immediately. If Rst_n falls during WRITE before the edge, MW drops asynchronously and no write commits.
- A request presented while req_ready=0 is ignored. The requester must hold it until accepted.

Test Plan:
- Word store then load: sw 0xDEADBEEF @0x10, then lw @0x10 → MW pulse with Addr=0x10, WD=0xDEADBEEF; load returns resp_rdata=0xDEADBEEF, resp_err=0, resp_valid 2 edges after acceptance.
- Byte store read-modify-write: word @0x20=0x11223344, sb 0xAA @0x22 → MR cycle then MW cycle with WD=0x11AA3344; response 3 edges after acceptance.
- Sign/zero extension: word @0x30=0x0000F080. lb @0x30 → 0xFFFFFF80; lbu @0x30 → 0x00000080; lh @0x30 → 0xFFFFF080; lhu @0x32 → 0x00000000.
- Errors: lw @0x13, sh @0x05, size=11, and lw @0x400 (MEM_WORDS=256) → each gives resp_err=1, resp_rdata=0, MR=MW=0 throughout, resp_valid 1 edge after acceptance.
- Back-pressure: hold resp_ready=0 for 5 cycles after a load → resp_valid and resp_rdata stable, req_ready=0, a new req_valid is ignored; release → IDLE next cycle.
- Reset mid-write: assert Rst_n=0 during WRITE of sw 0x55 @0x40 → MW=0 immediately; a later lw @0x40 returns the prior contents.
